// File: rtl/progmem.sv
// progmem: instruction memory for one core. After reset it loads a program
// image as a little-endian byte stream (ld_* valid/ready port), then raises
// core_en and serves registered fetches with 1-cycle read latency.
// Backpressure: ld_ready is high only while loading; loader bytes are
// ignored in RUN. The fetch read register is gated by en.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              fetch enable (gates the read register only)
//   progmem_addr    fetch address      -> progmem_data (registered, 0 in LOAD)
//   ld_valid/ready  loader byte handshake, ld_byte data, ld_last end of image
//   core_en         high once the image is loaded (RUN state)
//   ld_count        words written since reset
//   ld_err          sticky: image ended mid-word (word was zero-padded)
module progmem #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] progmem_addr,
    output logic [INST_W-1:0] progmem_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              core_en,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
);
    localparam int BPI   = INST_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BI_W  = (BPI > 1) ? $clog2(BPI) : 1;

    localparam logic [BI_W-1:0]   BI_LAST   = BI_W'(BPI - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BI_W-1:0]   r_bi;
    logic [INST_W-1:0] r_asm;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_ld_count;
    logic              r_ld_err;
    logic [INST_W-1:0] r_progmem_data;
    logic [INST_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_word_done;
    logic              w_short;
    logic              w_last_word;
    logic [INST_W-1:0] w_word;

    assign w_accept    = ld_valid && (r_state == S_LOAD);
    // A word completes on its last byte, or early when the image ends.
    assign w_word_done = w_accept && (ld_last || (r_bi == BI_LAST));
    assign w_short     = w_accept && ld_last && (r_bi != BI_LAST);
    // Leave LOAD on end of image or when the top address has been written.
    assign w_last_word = w_word_done && (ld_last || (r_wr_addr == ADDR_LAST));

    // Word to write: bytes already assembled below bi, the incoming byte at
    // bi, zeros above bi. The zeros only matter for a short final word, and
    // they also keep stale bytes of the previous word out of memory.
    always_comb begin
        w_word = '0;
        for (int j = 0; j < BPI; j++) begin
            if (BI_W'(j) < r_bi) begin
                w_word[8*j +: 8] = r_asm[8*j +: 8];
            end else if (BI_W'(j) == r_bi) begin
                w_word[8*j +: 8] = ld_byte;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        core_en     = 1'b0;
        case (r_state)
            S_LOAD: begin
                ld_ready = 1'b1;
                if (w_last_word) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_en = 1'b1;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Loader byte assembly and word bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bi       <= '0;
            r_asm      <= '0;
            r_wr_addr  <= '0;
            r_ld_count <= '0;
            r_ld_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_bi       <= '0;
                r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                r_ld_count <= r_ld_count + (ADDR_W+1)'(1);
            end else begin
                r_bi  <= r_bi + BI_W'(1);
                r_asm <= w_word;
            end
            if (w_short) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    // Storage array: no reset, so it maps onto RAM. A write coinciding with
    // reset is dropped, which discards a word completing on that edge.
    always_ff @(posedge clk) begin
        if (!rst && w_word_done) begin
            r_mem[r_wr_addr] <= w_word;
        end
    end

    // Fetch read register: held at 0 (NOP) while loading, so writes and
    // reads never overlap in time.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_LOAD)) begin
            r_progmem_data <= '0;
        end else if (en) begin
            r_progmem_data <= r_mem[progmem_addr];
        end
    end

    assign progmem_data = r_progmem_data;
    assign ld_count     = r_ld_count;
    assign ld_err       = r_ld_err;

endmodule

// File: tb/tb_progmem.sv
// tb_progmem: self-checking bench for progmem (INST_W=32, ADDR_W=8).
// A queue-based reference model updates on each rising edge; one compare
// process checks every DUT output against it on each falling edge.
module tb_progmem;
    localparam int INST_W = 32;
    localparam int ADDR_W = 8;
    localparam int BPI    = INST_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [ADDR_W-1:0] progmem_addr = '0;
    logic [INST_W-1:0] progmem_data;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [7:0]        ld_byte = 8'h00;
    logic              ld_last = 1'b0;
    logic              core_en;
    logic [ADDR_W:0]   ld_count;
    logic              ld_err;

    progmem #(.INST_W(INST_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .progmem_addr (progmem_addr),
        .progmem_data (progmem_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .core_en      (core_en),
        .ld_count     (ld_count),
        .ld_err       (ld_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    logic        m_err = 1'b0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_mem[DEPTH];
    bit          m_known[DEPTH];
    logic [31:0] m_data = '0;
    bit          m_data_known = 1'b1;

    initial begin
        logic [31:0] word;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 1'b0;
                m_cnt = 0;
                m_err = 1'b0;
                m_bytes.delete();
                m_data = '0;
                m_data_known = 1'b1;
            end else if (!m_run) begin
                m_data = '0;
                m_data_known = 1'b1;
                if (ld_valid) begin
                    m_bytes.push_back(ld_byte);
                    if (m_bytes.size() == BPI || ld_last) begin
                        word = '0;
                        for (int i = 0; i < m_bytes.size(); i++)
                            word = word | (32'(m_bytes[i]) << (8 * i));
                        if (m_bytes.size() < BPI) m_err = 1'b1;
                        m_mem[m_cnt]   = word;
                        m_known[m_cnt] = 1'b1;
                        m_cnt++;
                        m_bytes.delete();
                        if (ld_last || m_cnt == DEPTH) m_run = 1'b1;
                    end
                end
            end else if (en) begin
                m_data       = m_mem[progmem_addr];
                m_data_known = m_known[progmem_addr];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("core_en", 64'(core_en), 64'(m_run));
            chk("ld_ready", 64'(ld_ready), 64'(!m_run));
            chk("ld_count", 64'(ld_count), 64'(m_cnt));
            chk("ld_err", 64'(ld_err), 64'(m_err));
            if (m_data_known) chk("progmem_data", 64'(progmem_data), 64'(m_data));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        en = 1'b1;
        progmem_addr = a;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  s2 [8];
        logic [7:0]  s5 [4];
        logic [31:0] exp_w;
        int          n;

        s2 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        s5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Reset held for two cycles from time 0
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst core_en", 64'(core_en), 64'(0));
        chk("rst ld_ready", 64'(ld_ready), 64'(1));
        chk("rst progmem_data", 64'(progmem_data), 64'(0));
        chk("rst ld_count", 64'(ld_count), 64'(0));
        chk("rst ld_err", 64'(ld_err), 64'(0));

        // Two-word load then fetch
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("two-word core_en before last", 64'(core_en), 64'(0));
            send(s2[i], i == 7);
        end
        chk("two-word core_en", 64'(core_en), 64'(1));
        chk("two-word ld_count", 64'(ld_count), 64'(2));
        chk("two-word ld_err", 64'(ld_err), 64'(0));
        fetch(8'd1);
        chk("fetch 1", 64'(progmem_data), 64'(32'hDEADBEEF));
        fetch(8'd0);
        chk("fetch 0", 64'(progmem_data), 64'(32'h00000013));

        // Fetch hold with en low
        en = 1'b0;
        progmem_addr = 8'd1;
        idle(3);
        chk("hold data", 64'(progmem_data), 64'(32'h00000013));
        en = 1'b1;
        @(negedge clk);
        chk("hold release", 64'(progmem_data), 64'(32'hDEADBEEF));

        // Loader ignored in RUN
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        chk("run ignores ld count", 64'(ld_count), 64'(2));
        chk("run ld_ready", 64'(ld_ready), 64'(0));

        // Reset from RUN, partial final word with gaps
        do_reset();
        chk("reset from run core_en", 64'(core_en), 64'(0));
        send(8'h34, 1'b0);
        idle(3);
        send(8'h12, 1'b1);
        chk("partial ld_err", 64'(ld_err), 64'(1));
        chk("partial ld_count", 64'(ld_count), 64'(1));
        chk("partial core_en", 64'(core_en), 64'(1));
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        chk("partial no accept", 64'(ld_count), 64'(1));
        fetch(8'd0);
        chk("partial word", 64'(progmem_data), 64'(32'h00001234));

        // Reset in the middle of a load
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(i + 1), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) send(s5[i], i == 3);
        chk("midload ld_count", 64'(ld_count), 64'(1));
        chk("midload ld_err", 64'(ld_err), 64'(0));
        fetch(8'd0);
        chk("midload word", 64'(progmem_data), 64'(32'hDDCCBBAA));

        // Full fill without ld_last
        do_reset();
        for (int i = 0; i < DEPTH * BPI; i++) begin
            if (i == DEPTH * BPI - 1) chk("full core_en before last", 64'(core_en), 64'(0));
            send(pat(i), 1'b0);
            if ($urandom_range(0, 15) == 0) idle(1);
        end
        chk("full core_en", 64'(core_en), 64'(1));
        chk("full ld_count", 64'(ld_count), 64'(256));
        chk("full ld_ready", 64'(ld_ready), 64'(0));
        send(8'hFF, 1'b0);
        chk("full no wrap", 64'(ld_count), 64'(256));
        exp_w = {pat(1023), pat(1022), pat(1021), pat(1020)};
        fetch(8'd255);
        chk("full fetch 255", 64'(progmem_data), 64'(exp_w));
        exp_w = {pat(3), pat(2), pat(1), pat(0)};
        fetch(8'd0);
        chk("full fetch 0", 64'(progmem_data), 64'(exp_w));

        // Randomized loads and fetches against the model
        for (int t = 0; t < 20; t++) begin
            do_reset();
            n = $urandom_range(1, 60);
            for (int i = 0; i < n; i++) begin
                send(8'($urandom), i == n - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            for (int c = 0; c < 30; c++) begin
                en           = 1'($urandom_range(0, 1));
                progmem_addr = 8'($urandom_range(0, 20));
                ld_valid     = 1'($urandom_range(0, 1));
                ld_byte      = 8'($urandom);
                ld_last      = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
